// File: rtl/ready_bits_update_sched.sv
// ready_bits_update_sched: round-robin sequencer of per-requester ready-bit updates into a single-ported demux
// Ports:
//   clk, rst (sync, active-low)
//   req_valid[k], req_wfid slice k, req_info slice k : push side of requester k FIFO
//   req_ready[k]  : FIFO k not full (registered count, no pop-through)
//   demux_addr/in/en : registered drive of the demux
//   grant_id      : requester whose valid entry was last delivered
//   bad_wfid      : one-cycle pulse for a popped entry with wfid >= WF_PER_CU
//   overflow_err  : sticky push-while-full flag
module ready_bits_update_sched #(
    parameter int WF_ID_LENGTH             = 6,
    parameter int WF_PER_CU                = 40,
    parameter int ISSUE_GPR_RD_BITS_LENGTH = 8,
    parameter int TOTAL_INFO_LENGTH        = ISSUE_GPR_RD_BITS_LENGTH,
    parameter int NUM_REQ                  = 3,
    parameter int FIFO_DEPTH               = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*WF_ID_LENGTH-1:0]      req_wfid,
    input  logic [NUM_REQ*TOTAL_INFO_LENGTH-1:0] req_info,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [WF_ID_LENGTH-1:0]              demux_addr,
    output logic [TOTAL_INFO_LENGTH-1:0]         demux_in,
    output logic                                 demux_en,
    output logic [1:0]                           grant_id,
    output logic                                 bad_wfid,
    output logic                                 overflow_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    // count needs one extra bit to represent a full FIFO
    localparam int CW = PW + 1;

    logic [CW-1:0]                count   [NUM_REQ];
    logic [PW-1:0]                wr_ptr  [NUM_REQ];
    logic [PW-1:0]                rd_ptr  [NUM_REQ];
    logic [WF_ID_LENGTH-1:0]      wf_mem  [NUM_REQ][FIFO_DEPTH];
    logic [TOTAL_INFO_LENGTH-1:0] inf_mem [NUM_REQ][FIFO_DEPTH];
    logic [NUM_REQ-1:0]           full, nonempty, push, pop;
    logic [1:0]                   last_grant, win, idx;
    logic                         grant, win_ok;
    logic [WF_ID_LENGTH-1:0]      win_wfid;
    logic [TOTAL_INFO_LENGTH-1:0] win_info;

    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            full[k]     = count[k] == CW'(FIFO_DEPTH);
            nonempty[k] = count[k] != '0;
            push[k]     = req_valid[k] && !full[k];
        end
    end

    assign req_ready = ~full;

    // round-robin search starting just after the previous winner
    always_comb begin
        grant = 1'b0;
        win   = last_grant;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = 2'((int'(last_grant) + i) % NUM_REQ);
            if (!grant && nonempty[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int k = 0; k < NUM_REQ; k++)
            pop[k] = grant && (win == 2'(k));
    end

    assign win_wfid = wf_mem[win][rd_ptr[win]];
    assign win_info = inf_mem[win][rd_ptr[win]];
    assign win_ok   = int'(win_wfid) < WF_PER_CU;

    // storage carries no reset; occupancy is tracked by count alone
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (push[k]) begin
                wf_mem[k][wr_ptr[k]]  <= req_wfid[k*WF_ID_LENGTH +: WF_ID_LENGTH];
                inf_mem[k][wr_ptr[k]] <= req_info[k*TOTAL_INFO_LENGTH +: TOTAL_INFO_LENGTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                count[k]  <= '0;
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
            last_grant   <= 2'(NUM_REQ - 1);
            demux_addr   <= '0;
            demux_in     <= '0;
            demux_en     <= 1'b0;
            grant_id     <= '0;
            bad_wfid     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (push[k])
                    wr_ptr[k] <= wr_ptr[k] + PW'(1);
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + PW'(1);
                count[k] <= count[k] + CW'(push[k]) - CW'(pop[k]);
            end
            if (|(req_valid & full))
                overflow_err <= 1'b1;
            demux_en <= grant && win_ok;
            bad_wfid <= grant && !win_ok;
            if (grant) begin
                last_grant <= win;
                // address loads even for a bad wfid so it is visible for debug
                demux_addr <= win_wfid;
                if (win_ok) begin
                    demux_in <= win_info;
                    grant_id <= win;
                end
            end
        end
    end
endmodule

// File: tb/tb_ready_bits_update_sched.sv
module tb_ready_bits_update_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [17:0] req_wfid = '0;
    logic [23:0] req_info = '0;
    logic [2:0]  req_ready;
    logic [5:0]  demux_addr;
    logic [7:0]  demux_in;
    logic        demux_en;
    logic [1:0]  grant_id;
    logic        bad_wfid;
    logic        overflow_err;
    int vectors = 0;
    int miscompares = 0;

    ready_bits_update_sched dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_wfid(req_wfid),
        .req_info(req_info),
        .req_ready(req_ready),
        .demux_addr(demux_addr),
        .demux_in(demux_in),
        .demux_en(demux_en),
        .grant_id(grant_id),
        .bad_wfid(bad_wfid),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input int wf, input int info);
        req_valid[k] = 1'b1;
        req_wfid[k*6 +: 6] = 6'(wf);
        req_info[k*8 +: 8] = 8'(info);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        req_valid = '0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        vectors++;
        if (demux_en !== 1'b0) begin miscompares++; $display("FAIL reset_en got %b want 0", demux_en); end
        vectors++;
        if (bad_wfid !== 1'b0) begin miscompares++; $display("FAIL reset_bad got %b want 0", bad_wfid); end
        vectors++;
        if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", overflow_err); end
        vectors++;
        if (demux_addr !== 6'd0) begin miscompares++; $display("FAIL reset_addr got %0d want 0", demux_addr); end
        vectors++;
        if (demux_in !== 8'd0) begin miscompares++; $display("FAIL reset_in got %0h want 0", demux_in); end
        vectors++;
        if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset_gid got %0d want 0", grant_id); end
        vectors++;
        if (req_ready !== 3'b111) begin miscompares++; $display("FAIL reset_ready got %b want 111", req_ready); end
    endtask

    task automatic test_single;
        do_reset();
        set_req(1, 7, 5);
        step();
        req_valid = '0;
        vectors++;
        if (demux_en !== 1'b0) begin miscompares++; $display("FAIL single_c1_en got %b want 0", demux_en); end
        step();
        vectors++;
        if (demux_en !== 1'b1) begin miscompares++; $display("FAIL single_c2_en got %b want 1", demux_en); end
        vectors++;
        if (demux_addr !== 6'd7) begin miscompares++; $display("FAIL single_addr got %0d want 7", demux_addr); end
        vectors++;
        if (demux_in !== 8'h05) begin miscompares++; $display("FAIL single_in got %0h want 5", demux_in); end
        vectors++;
        if (grant_id !== 2'd1) begin miscompares++; $display("FAIL single_gid got %0d want 1", grant_id); end
        step();
        vectors++;
        if (demux_en !== 1'b0) begin miscompares++; $display("FAIL single_c3_en got %b want 0", demux_en); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        set_req(0, 3, 8'h10);
        set_req(1, 4, 8'h11);
        set_req(2, 5, 8'h12);
        step();
        req_valid = '0;
        step();
        for (int t = 0; t < 3; t++) begin
            vectors++;
            if (demux_en !== 1'b1) begin miscompares++; $display("FAIL b2b_en c%0d got %b want 1", t + 2, demux_en); end
            vectors++;
            if (demux_addr !== 6'(3 + t)) begin miscompares++; $display("FAIL b2b_addr c%0d got %0d want %0d", t + 2, demux_addr, 3 + t); end
            vectors++;
            if (grant_id !== 2'(t)) begin miscompares++; $display("FAIL b2b_gid c%0d got %0d want %0d", t + 2, grant_id, t); end
            vectors++;
            if (demux_in !== 8'(8'h10 + t)) begin miscompares++; $display("FAIL b2b_in c%0d got %0h want %0h", t + 2, demux_in, 8'h10 + t); end
            step();
        end
        vectors++;
        if (demux_en !== 1'b0) begin miscompares++; $display("FAIL b2b_c5_en got %b want 0", demux_en); end
    endtask

    // requester 0 pushes every cycle; 1 and 2 take slots early so FIFO 0 fills
    task automatic test_overflow;
        int exp_en [13] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int exp_addr [13] = '{0, 0, 10, 20, 30, 11, 21, 31, 12, 13, 14, 15, 0};
        do_reset();
        for (int c = 0; c < 13; c++) begin
            req_valid = '0;
            if (c <= 6) set_req(0, 10 + c, c);
            if (c <= 1) begin
                set_req(1, 20 + c, 0);
                set_req(2, 30 + c, 0);
            end
            vectors++;
            if (demux_en !== 1'(exp_en[c])) begin miscompares++; $display("FAIL ovf_en c%0d got %b want %0d", c, demux_en, exp_en[c]); end
            if (exp_en[c] == 1) begin
                vectors++;
                if (demux_addr !== 6'(exp_addr[c])) begin miscompares++; $display("FAIL ovf_addr c%0d got %0d want %0d", c, demux_addr, exp_addr[c]); end
            end
            if (c == 5) begin
                vectors++;
                if (req_ready !== 3'b111) begin miscompares++; $display("FAIL ovf_ready_c5 got %b want 111", req_ready); end
            end
            if (c == 6) begin
                vectors++;
                if (req_ready !== 3'b110) begin miscompares++; $display("FAIL ovf_ready_c6 got %b want 110", req_ready); end
                vectors++;
                if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL ovf_err_c6 got %b want 0", overflow_err); end
            end
            if (c == 7 || c == 12) begin
                vectors++;
                if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_err c%0d got %b want 1", c, overflow_err); end
            end
            step();
        end
        req_valid = '0;
    endtask

    task automatic test_bad_wfid;
        do_reset();
        set_req(2, 45, 3);
        step();
        req_valid = '0;
        set_req(2, 9, 4);
        step();
        req_valid = '0;
        vectors++;
        if (bad_wfid !== 1'b1) begin miscompares++; $display("FAIL bad_pulse got %b want 1", bad_wfid); end
        vectors++;
        if (demux_en !== 1'b0) begin miscompares++; $display("FAIL bad_en got %b want 0", demux_en); end
        vectors++;
        if (demux_addr !== 6'd45) begin miscompares++; $display("FAIL bad_addr got %0d want 45", demux_addr); end
        step();
        vectors++;
        if (bad_wfid !== 1'b0) begin miscompares++; $display("FAIL bad_next_pulse got %b want 0", bad_wfid); end
        vectors++;
        if (demux_en !== 1'b1) begin miscompares++; $display("FAIL bad_next_en got %b want 1", demux_en); end
        vectors++;
        if (demux_addr !== 6'd9) begin miscompares++; $display("FAIL bad_next_addr got %0d want 9", demux_addr); end
        vectors++;
        if (demux_in !== 8'd4) begin miscompares++; $display("FAIL bad_next_in got %0h want 4", demux_in); end
        vectors++;
        if (grant_id !== 2'd2) begin miscompares++; $display("FAIL bad_next_gid got %0d want 2", grant_id); end
        step();
        vectors++;
        if (demux_en !== 1'b0 || bad_wfid !== 1'b0) begin miscompares++; $display("FAIL bad_idle got en=%b bad=%b want 0/0", demux_en, bad_wfid); end
        vectors++;
        if (req_ready !== 3'b111) begin miscompares++; $display("FAIL bad_ready got %b want 111", req_ready); end
    endtask

    task automatic test_rotation;
        int tally [3] = '{0, 0, 0};
        do_reset();
        for (int c = 0; c < 15; c++) begin
            req_valid = '0;
            if (c <= 3)
                for (int k = 0; k < 3; k++) set_req(k, k * 8 + c, c);
            if (c >= 2 && c <= 13) begin
                vectors++;
                if (demux_en !== 1'b1) begin miscompares++; $display("FAIL rot_en c%0d got %b want 1", c, demux_en); end
                vectors++;
                if (grant_id !== 2'((c - 2) % 3)) begin miscompares++; $display("FAIL rot_gid c%0d got %0d want %0d", c, grant_id, (c - 2) % 3); end
                vectors++;
                if (demux_addr !== 6'(((c - 2) % 3) * 8 + (c - 2) / 3)) begin miscompares++; $display("FAIL rot_addr c%0d got %0d want %0d", c, demux_addr, ((c - 2) % 3) * 8 + (c - 2) / 3); end
                vectors++;
                if (demux_in !== 8'((c - 2) / 3)) begin miscompares++; $display("FAIL rot_in c%0d got %0d want %0d", c, demux_in, (c - 2) / 3); end
                if (demux_en === 1'b1 && grant_id < 2'd3) tally[grant_id]++;
            end
            if (c == 14) begin
                vectors++;
                if (demux_en !== 1'b0) begin miscompares++; $display("FAIL rot_end_en got %b want 0", demux_en); end
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (tally[k] != 4) begin miscompares++; $display("FAIL rot_tally r%0d got %0d want 4", k, tally[k]); end
        end
    endtask

    // entered with overflow_err still set and last_grant=0 from the overflow scenario
    task automatic test_reset_mid;
        req_valid = '0;
        vectors++;
        if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL mid_pre_ovf got %b want 1", overflow_err); end
        for (int c = 0; c < 3; c++) begin
            req_valid = '0;
            for (int k = 0; k < 3; k++) set_req(k, k * 8 + c, c);
            if (c == 2) begin
                vectors++;
                if (demux_en !== 1'b1 || grant_id !== 2'd1 || demux_addr !== 6'd8) begin
                    miscompares++;
                    $display("FAIL mid_pre_out got en=%b gid=%0d addr=%0d want 1/1/8", demux_en, grant_id, demux_addr);
                end
            end
            step();
        end
        do_reset();
        vectors++;
        if (demux_en !== 1'b0) begin miscompares++; $display("FAIL mid_en got %b want 0", demux_en); end
        vectors++;
        if (req_ready !== 3'b111) begin miscompares++; $display("FAIL mid_ready got %b want 111", req_ready); end
        vectors++;
        if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL mid_ovf got %b want 0", overflow_err); end
        for (int c = 0; c < 6; c++) begin
            step();
            vectors++;
            if (demux_en !== 1'b0 || bad_wfid !== 1'b0) begin miscompares++; $display("FAIL mid_stale c%0d got en=%b bad=%b want 0/0", c, demux_en, bad_wfid); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_wfid();
        test_rotation();
        test_overflow();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
